// File: rtl/buzzer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | buzzer_pkg : constants and types shared by the buzzer blocks        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package buzzer_pkg;

  localparam int CMP_W   = 22;
  localparam int CMP_MIN = 2500;
  localparam int CMP_RST = 250000;
  localparam int CLK_HZ  = 50_000_000;

  typedef logic [CMP_W-1:0] cmp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tone_state_e;

endpackage : buzzer_pkg
`default_nettype wire

// File: rtl/buzzer_tone_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | buzzer_tone_gen_if : request/output bundle of the tone generator    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface buzzer_tone_gen_if #(
  parameter int CMP_W = buzzer_pkg::CMP_W
);

  logic             en_i;
  logic [CMP_W-1:0] cmp_freq_i;
  logic             buzzer_o;
  logic             busy_o;
  logic             period_tick_o;

  modport master (
    output en_i,
    output cmp_freq_i,
    input  buzzer_o,
    input  busy_o,
    input  period_tick_o
  );

  modport slave (
    input  en_i,
    input  cmp_freq_i,
    output buzzer_o,
    output busy_o,
    output period_tick_o
  );

endinterface : buzzer_tone_gen_if
`default_nettype wire

// File: rtl/buzzer_tone_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | buzzer_tone_gen : glitch-free square-wave tone, f = clk / (2*cmp)   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module buzzer_tone_gen #(
  parameter int CMP_W   = buzzer_pkg::CMP_W,
  parameter int CMP_MIN = buzzer_pkg::CMP_MIN,
  parameter int CMP_RST = buzzer_pkg::CMP_RST
) (
  input  wire logic        clk_i,
  input  wire logic        rst_n_i,
  buzzer_tone_gen_if.slave bus
);

  import buzzer_pkg::*;

  localparam logic [CMP_W-1:0] c_cmp_min = CMP_W'(CMP_MIN);
  localparam logic [CMP_W-1:0] c_cmp_rst = CMP_W'(CMP_RST);
  localparam logic [CMP_W-1:0] c_one     = CMP_W'(1);

  tone_state_e      r_state;
  logic [CMP_W-1:0] r_cnt;
  logic [CMP_W-1:0] r_cmp_act;
  logic             r_buzzer;
  logic             r_busy;
  logic             r_tick;

  logic [CMP_W-1:0] w_cmp_eff;
  logic             w_terminal;

  assign w_cmp_eff  = (bus.cmp_freq_i < c_cmp_min) ? c_cmp_min : bus.cmp_freq_i;
  assign w_terminal = (r_cnt == (r_cmp_act - c_one));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cmp_act <= c_cmp_rst;
      r_buzzer  <= 1'b0;
      r_busy    <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt    <= '0;
          r_buzzer <= 1'b0;
          if (bus.en_i) begin
            r_cmp_act <= w_cmp_eff;
            r_buzzer  <= 1'b1;
            r_tick    <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= RUN;
          end
        end

        RUN: begin
          // A stop in the low phase wins over the terminal count so no runt high pulse starts.
          if (!bus.en_i && !r_buzzer) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_terminal) begin
            r_cnt    <= '0;
            r_buzzer <= ~r_buzzer;
            if (!r_buzzer) begin
              r_cmp_act <= w_cmp_eff;
              r_tick    <= 1'b1;
            end else if (!bus.en_i) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + c_one;
            if (!bus.en_i) begin
              r_state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (w_terminal) begin
            r_cnt    <= '0;
            r_buzzer <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_cnt <= r_cnt + c_one;
          end
        end

        default: begin
          r_cnt    <= '0;
          r_buzzer <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.buzzer_o      = r_buzzer;
  assign bus.busy_o        = r_busy;
  assign bus.period_tick_o = r_tick;

endmodule : buzzer_tone_gen
`default_nettype wire

// File: tb/tb_buzzer_tone_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_buzzer_tone_gen : scoreboard bench against a period-position model |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_buzzer_tone_gen;

  localparam int CMP_W   = 22;
  localparam int TB_MIN  = 4;

  typedef struct packed {
    logic buzz;
    logic busy;
    logic tick;
  } exp_t;

  logic clk_i;
  logic rst_n_i;

  buzzer_tone_gen_if #(.CMP_W(CMP_W)) tb_if ();

  buzzer_tone_gen #(
    .CMP_W   (CMP_W),
    .CMP_MIN (TB_MIN)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (tb_if)
  );

  initial clk_i = 1'b0;
  always #10 clk_i = ~clk_i;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // Model: tone is either off, or at position m_pos (0..2*m_cmp-1) inside a period whose
  // first m_cmp cycles are high. m_stopping means the tone ends when the high half ends.
  bit m_on       = 1'b0;
  bit m_stopping = 1'b0;
  int m_pos      = 0;
  int m_cmp      = 0;

  function automatic int clamp(input int unsigned c);
    return (c < TB_MIN) ? TB_MIN : int'(c);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic en, input int unsigned cmp, output exp_t e);
    e.tick = 1'b0;
    if (!m_on) begin
      if (en) begin
        m_on       = 1'b1;
        m_stopping = 1'b0;
        m_cmp      = clamp(cmp);
        m_pos      = 0;
        e.tick     = 1'b1;
      end
    end else begin
      if (!en && !m_stopping) begin
        if (m_pos >= m_cmp) m_on = 1'b0;
        else                m_stopping = 1'b1;
      end
      if (m_on) begin
        m_pos++;
        if (m_stopping && m_pos == m_cmp) begin
          m_on = 1'b0;
        end else if (m_pos == 2 * m_cmp) begin
          m_pos  = 0;
          m_cmp  = clamp(cmp);
          e.tick = 1'b1;
        end
      end
    end
    e.buzz = m_on && (m_pos < m_cmp);
    e.busy = m_on;
  endtask

  // Drive one cycle of stimulus at the falling edge and queue what the next rising edge must produce.
  task automatic step(input logic en, input int unsigned cmp);
    exp_t e;
    @(negedge clk_i);
    tb_if.en_i       = en;
    tb_if.cmp_freq_i = CMP_W'(cmp);
    model_step(en, cmp, e);
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("buzzer_o",      int'(tb_if.buzzer_o),      int'(e.buzz));
        check("busy_o",        int'(tb_if.busy_o),        int'(e.busy));
        check("period_tick_o", int'(tb_if.period_tick_o), int'(e.tick));
      end
    end
  end

  initial begin : stimulus
    logic        en_r;
    int unsigned c;

    rst_n_i          = 1'b0;
    tb_if.en_i       = 1'b0;
    tb_if.cmp_freq_i = '0;
    #5;
    check("rst_buzzer", int'(tb_if.buzzer_o),      0);
    check("rst_busy",   int'(tb_if.busy_o),        0);
    check("rst_tick",   int'(tb_if.period_tick_o), 0);
    repeat (3) @(posedge clk_i);
    #5 rst_n_i = 1'b1;

    // basic tone at cmp = 5
    repeat (2) step(1'b0, 5);
    repeat (30) step(1'b1, 5);

    // boundary reload: change to 8 on the 2nd high cycle of a 5-period
    for (int i = 0; i < 50; i++) begin
      if (m_on && m_cmp == 5 && m_pos == 1) break;
      step(1'b1, 5);
    end
    repeat (40) step(1'b1, 8);

    // clamp: 0 then 3 both become 4
    repeat (20) step(1'b1, 0);
    repeat (20) step(1'b1, 3);
    repeat (12) step(1'b0, 3);

    // stop on the 2nd high cycle of cmp = 6
    for (int i = 0; i < 60; i++) begin
      if (m_on && m_cmp == 6 && m_pos == 1) break;
      step(1'b1, 6);
    end
    repeat (15) step(1'b0, 6);

    // stop on the 2nd low cycle of cmp = 5
    for (int i = 0; i < 60; i++) begin
      if (m_on && m_cmp == 5 && m_pos == 6) break;
      step(1'b1, 5);
    end
    repeat (6) step(1'b0, 5);

    // randomized enable and period requests
    en_r = 1'b1;
    c    = 5;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) en_r = ~en_r;
      if ($urandom_range(0, 7) == 0)  c = $urandom_range(0, 12);
      step(en_r, c);
    end
    repeat (30) step(1'b0, 4);

    // asynchronous reset in the middle of a high phase
    for (int i = 0; i < 60; i++) begin
      if (m_on && m_cmp == 7 && m_pos == 2) break;
      step(1'b1, 7);
    end
    @(posedge clk_i);
    #3 rst_n_i = 1'b0;
    #1;
    check("arst_buzzer", int'(tb_if.buzzer_o),      0);
    check("arst_busy",   int'(tb_if.busy_o),        0);
    check("arst_tick",   int'(tb_if.period_tick_o), 0);
    m_on       = 1'b0;
    m_stopping = 1'b0;
    #1 rst_n_i = 1'b1;
    repeat (20) step(1'b1, 9);
    repeat (20) step(1'b0, 9);

    @(posedge clk_i);
    #2;
    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_buzzer_tone_gen
`default_nettype wire
